// File: rtl/tree_node_bcast.sv
// Hierarchy node: broadcasts one upstream request to NUM_CHILD children,
// folds their responses into one result (OR / XOR / SUM) and returns it
// upstream. Per-child enable masks unpopulated children and a collection
// timeout aborts the transaction when a subtree stops answering.
module tree_node_bcast #(
  parameter int NUM_CHILD   = 10,
  parameter int DATA_W      = 16,
  parameter int REDUCE_MODE = 0,    // 0=OR, 1=XOR, 2=SUM modulo 2^DATA_W
  parameter int TIMEOUT     = 255   // 0 disables the timeout
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHILD-1:0]          child_en,
  input  logic                          up_req_valid,
  output logic                          up_req_ready,
  input  logic [DATA_W-1:0]             up_req_data,
  output logic [NUM_CHILD-1:0]          dn_req_valid,
  input  logic [NUM_CHILD-1:0]          dn_req_ready,
  output logic [DATA_W-1:0]             dn_req_data,
  input  logic [NUM_CHILD-1:0]          dn_rsp_valid,
  output logic [NUM_CHILD-1:0]          dn_rsp_ready,
  input  logic [NUM_CHILD*DATA_W-1:0]   dn_rsp_data,
  output logic                          up_rsp_valid,
  input  logic                          up_rsp_ready,
  output logic [DATA_W-1:0]             up_rsp_data,
  output logic                          up_rsp_err,
  output logic [NUM_CHILD-1:0]          up_rsp_miss,
  output logic [7:0]                    stale_cnt
);

  // Wide enough to hold TIMEOUT-1; a single bit when the timeout is disabled.
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BCAST,
    ST_COLLECT,
    ST_RESP
  } state_e;

  // Registered state.
  state_e                 state_q,    state_d;
  logic [DATA_W-1:0]      data_q,     data_d;
  logic [NUM_CHILD-1:0]   pend_req_q, pend_req_d;
  logic [NUM_CHILD-1:0]   pend_rsp_q, pend_rsp_d;
  logic [DATA_W-1:0]      acc_q,      acc_d;
  logic [TMO_W-1:0]       tmo_q,      tmo_d;
  logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;
  logic                   err_q,      err_d;
  logic [NUM_CHILD-1:0]   miss_q,     miss_d;
  logic [7:0]             stale_q,    stale_d;

  // Per-cycle results of the handshake/fold stage.
  logic                   active;
  logic [NUM_CHILD-1:0]   rsp_ready;
  logic [NUM_CHILD-1:0]   req_left;
  logic [NUM_CHILD-1:0]   rsp_left;
  logic [DATA_W-1:0]      acc_fold;
  logic [31:0]            n_stale;
  logic                   done;
  logic                   tmo_hit;

  // Combine two payloads with the configured reduction; 0 is the identity.
  function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    case (REDUCE_MODE)
      1:       fold = a ^ b;
      2:       fold = a + b;
      default: fold = a | b;
    endcase
  endfunction

  // Responses are always accepted outside reset so a misbehaving child can never
  // stall the node; unwanted ones are simply counted and dropped.
  assign rsp_ready = {NUM_CHILD{~rst}};
  assign active    = (state_q == ST_BCAST) || (state_q == ST_COLLECT);

  // Clear request bits on handshake and fold every wanted response of this cycle.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    req_left = pend_req_q;
    rsp_left = pend_rsp_q;
    acc_fold = acc_q;
    n_stale  = '0;
    if (state_q == ST_BCAST) begin
      req_left = pend_req_q & ~dn_req_ready;
    end
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (dn_rsp_valid[i] && rsp_ready[i]) begin
        // A response counts only once its request has been handed over.
        if (active && pend_rsp_q[i] && !pend_req_q[i]) begin
          acc_fold    = fold(acc_fold, dn_rsp_data[i*DATA_W +: DATA_W]);
          rsp_left[i] = 1'b0;
        end else begin
          n_stale = n_stale + 32'd1;
        end
      end
    end
  end

  // Completion looks at the registered request mask (so the broadcast phase has
  // really finished) and at the response mask after this cycle's responses.
  assign done    = (pend_req_q == '0) && (rsp_left == '0);
  assign tmo_hit = (TIMEOUT > 0) && (tmo_q == TMO_W'(TIMEOUT - 1));

  // Saturating count of discarded responses.
  always_comb begin
    stale_d = stale_q;
    if (n_stale > 32'(8'd255 - stale_q)) begin
      stale_d = 8'd255;
    end else begin
      stale_d = stale_q + n_stale[7:0];
    end
  end

  // Next-state and datapath updates of the transaction FSM.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    pend_req_d = pend_req_q;
    pend_rsp_d = pend_rsp_q;
    acc_d      = acc_q;
    tmo_d      = tmo_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    miss_d     = miss_q;

    case (state_q)
      ST_IDLE: begin
        if (up_req_valid) begin
          data_d     = up_req_data;
          pend_req_d = child_en;
          pend_rsp_d = child_en;
          acc_d      = '0;
          tmo_d      = '0;
          if (child_en == '0) begin
            // Nothing populated below: answer with the identity value at once.
            state_d    = ST_RESP;
            rsp_data_d = '0;
            err_d      = 1'b0;
            miss_d     = '0;
          end else begin
            state_d = ST_BCAST;
          end
        end
      end

      ST_BCAST, ST_COLLECT: begin
        pend_req_d = req_left;
        pend_rsp_d = rsp_left;
        acc_d      = acc_fold;
        tmo_d      = tmo_q + 1'b1;
        if (done) begin
          // Completion wins over a timeout landing in the same cycle.
          state_d    = ST_RESP;
          rsp_data_d = acc_fold;
          err_d      = 1'b0;
          miss_d     = '0;
        end else if (tmo_hit) begin
          // Abort: withdraw outstanding requests and report who never finished.
          state_d    = ST_RESP;
          rsp_data_d = acc_fold;
          err_d      = 1'b1;
          miss_d     = req_left | rsp_left;
          pend_req_d = '0;
          pend_rsp_d = '0;
        end else if ((state_q == ST_BCAST) && (pend_req_q == '0)) begin
          state_d = ST_COLLECT;
        end
      end

      ST_RESP: begin
        if (up_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Transaction state registers; reset drops any in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      pend_req_q <= '0;
      pend_rsp_q <= '0;
      acc_q      <= '0;
      tmo_q      <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      miss_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      data_q     <= data_d;
      pend_req_q <= pend_req_d;
      pend_rsp_q <= pend_rsp_d;
      acc_q      <= acc_d;
      tmo_q      <= tmo_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      miss_q     <= miss_d;
    end
  end

  // Stale-response counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stale_q <= '0;
    end else begin
      stale_q <= stale_d;
    end
  end

  // Outputs come straight from registers (plus reset for the response ready).
  assign up_req_ready = (state_q == ST_IDLE);
  assign dn_req_valid = (state_q == ST_BCAST) ? pend_req_q : '0;
  assign dn_req_data  = data_q;
  assign dn_rsp_ready = rsp_ready;
  assign up_rsp_valid = (state_q == ST_RESP);
  assign up_rsp_data  = (state_q == ST_RESP) ? rsp_data_q : '0;
  assign up_rsp_err   = (state_q == ST_RESP) ? err_q : 1'b0;
  assign up_rsp_miss  = (state_q == ST_RESP) ? miss_q : '0;
  assign stale_cnt    = stale_q;

endmodule
